// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int CLK_HZ         = 12_000_000;
    localparam int BAUD_9600_CLKS = CLK_HZ / 9600;

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect and bit-sample source.
// With UART_RX_MAJORITY_EN defined, sample_bit is the 2-of-3 vote of the last three rx_s values.
module uart_bit_sampler (
    input  logic hwclk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s,
    output logic start_edge,
    output logic sample_bit
);
    logic rx_meta;
    logic rx_d;

    // Reset to the idle-high level so releasing reset never looks like a start edge.
    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_edge = rx_d & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    logic rx_dd;

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) rx_dd <= 1'b1;
        else          rx_dd <= rx_d;
    end

    // Read one cycle after the nominal point: rx_dd, rx_d, rx_s are the -1, 0, +1 samples.
    assign sample_bit = (rx_s & rx_d) | (rx_s & rx_dd) | (rx_d & rx_dd);
`else
    assign sample_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver on the 12 MHz clock with a single-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling; every decision then lands one cycle later.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_9600_CLKS,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       hwclk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_d;
    logic          rx_valid_d, frame_err_d, overrun_d;
    logic          rx_s_unused, start_edge, sample_bit;
    logic          nominal, decide;

    uart_bit_sampler u_sampler (
        .hwclk      (hwclk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_s       (rx_s_unused),
        .start_edge (start_edge),
        .sample_bit (sample_bit)
    );

    // The counter restarts at the nominal point; the decision may trail it by a cycle.
    assign nominal = (state_q == START) ? (cnt_q == HALF_LAST)
                                        : ((state_q != IDLE) && (cnt_q == BIT_LAST));

`ifdef UART_RX_MAJORITY_EN
    logic nominal_q;

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) nominal_q <= 1'b0;
        else          nominal_q <= nominal;
    end

    assign decide = nominal_q;
`else
    assign decide = nominal;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data;
        rx_valid_d  = rx_valid & ~rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (state_q != IDLE) cnt_d = nominal ? '0 : cnt_q + CW'(1);

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (decide) begin
                    if (!sample_bit) begin
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d = {sample_bit, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    if (!sample_bit) begin
                        frame_err_d = 1'b1;
                    end else if (!rx_valid || rx_ready) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hwclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: frame-level reference model plus directed and random traffic.
module tb_uart_rx_sampler;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       hwclk   = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, overrun;

    uart_rx_sampler #(.CLKS_PER_BIT(C)) dut (
        .hwclk     (hwclk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 hwclk = ~hwclk;

    // One entry per line event: fe is the first edge the synchroniser sees the line low,
    // end_e the edge at which the receiver makes its final decision for that event.
    typedef struct {
        int         fe;
        int         end_e;
        bit         good_start;
        bit         stop;
        logic [7:0] data;
    } frame_t;

    frame_t     q[$];
    logic [7:0] got[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         fe_seen = 0;
    int         ov_seen = 0;
    int         rise_e = 0;
    int         last_fe = 0;
    int         ready_mode = 0;
    logic       rv_prev = 1'b0;
    logic       m_valid = 1'b0, m_busy = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge hwclk)
        rx_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);

    // Reference model: advances once per clock edge from the queued line events.
    always @(posedge hwclk) begin : model
        logic hs, was;
        cyc++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
        if (rx_valid && !rv_prev) rise_e = cyc - 1;
        rv_prev = rx_valid;
        if (!reset_n) begin
            q.delete();
            m_valid = 1'b0; m_data = 8'h00; m_fe = 1'b0; m_ov = 1'b0; m_busy = 1'b0;
        end else begin
            hs  = m_valid && rx_ready;
            was = m_valid;
            m_fe = 1'b0;
            m_ov = 1'b0;
            if (hs) m_valid = 1'b0;
            if (q.size() > 0 && q[0].end_e == cyc) begin
                if (q[0].good_start) begin
                    if (!q[0].stop)       m_fe = 1'b1;
                    else if (!was || hs) begin m_valid = 1'b1; m_data = q[0].data; end
                    else                  m_ov = 1'b1;
                end
                void'(q.pop_front());
            end
            m_busy = (q.size() > 0) && (cyc >= q[0].fe + 2);
        end
    end

    always @(negedge hwclk) begin
        if (!reset_n) begin
            check("reset_rx_valid", rx_valid, 0);
            check("reset_rx_data", rx_data, 0);
            check("reset_busy", busy, 0);
            check("reset_frame_err", frame_err, 0);
            check("reset_overrun", overrun, 0);
        end else begin
            check("rx_valid", rx_valid, m_valid);
            check("busy", busy, m_busy);
            check("frame_err", frame_err, m_fe);
            check("overrun", overrun, m_ov);
            if (m_valid) check("rx_data", rx_data, m_data);
        end
    end

    task automatic do_reset(input int n);
        @(posedge hwclk);
        #2 reset_n = 1'b0;
        rx = 1'b1;
        repeat (n) @(posedge hwclk);
        #2 reset_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic v);
        repeat (n) begin
            @(negedge hwclk);
            rx = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input bit vote_glitch,
                              input int abort_bit);
        frame_t     fr;
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int t = 0; t < 10 * C; t++) begin
            @(negedge hwclk);
            if (t == 0) begin
                fr.fe = cyc + 1;
                fr.end_e = fr.fe + 2 + H + 9 * C + MAJ;
                fr.good_start = 1'b1;
                fr.stop = stop;
                fr.data = data;
                last_fe = fr.fe;
                q.push_back(fr);
            end
            if (abort_bit >= 0 && t == (abort_bit + 1) * C + 3) begin
                do_reset(5);
                return;
            end
            rx = bits[t / C];
            if (vote_glitch && (t % C == H) && (t / C >= 1) && (t / C <= 8)) rx = ~rx;
        end
    endtask

    task automatic send_glitch(input int len);
        frame_t fr;
        for (int t = 0; t < len + H + 8; t++) begin
            @(negedge hwclk);
            if (t == 0) begin
                fr.fe = cyc + 1;
                fr.end_e = fr.fe + 2 + H + MAJ;
                fr.good_start = 1'b0;
                fr.stop = 1'b0;
                fr.data = 8'h00;
                q.push_back(fr);
            end
            rx = (t >= len);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(4);
        idle(10, 1'b1);

        // Two back-to-back bytes with the consumer always ready.
        ready_mode = 1;
        got.delete(); fe_seen = 0; ov_seen = 0;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(5, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(20, 1'b1);
        check("t1_count", got.size(), 2);
        check("t1_byte0", got[0], 8'hA5);
        check("t1_byte1", got[1], 8'h3C);
        check("t1_frame_err", fe_seen, 0);
        check("t1_overrun", ov_seen, 0);
        // 2 sync cycles + half bit + 9 bits = 2 + 8 + 144 = 154 edges after first low capture.
        check("t1_latency", rise_e - last_fe, 154 + MAJ);

        // Framing error, held-low line, then a good byte.
        got.delete(); fe_seen = 0; ov_seen = 0;
        send_frame(8'h55, 1'b0, 1'b0, -1);
        idle(40, 1'b0);
        idle(10, 1'b1);
        check("t2_break_busy", busy, 0);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        idle(20, 1'b1);
        check("t2_frame_err", fe_seen, 1);
        check("t2_count", got.size(), 1);
        check("t2_byte", got[0], 8'h12);

        // Short low glitch on an idle line.
        got.delete(); fe_seen = 0; ov_seen = 0;
        send_glitch(4);
        check("t3_busy", busy, 0);
        check("t3_count", got.size(), 0);
        check("t3_errors", fe_seen + ov_seen, 0);

        // Consumer stalled: second byte overruns, first byte is held.
        ready_mode = 0;
        got.delete(); fe_seen = 0; ov_seen = 0;
        send_frame(8'h01, 1'b1, 1'b0, -1);
        idle(5, 1'b1);
        send_frame(8'h02, 1'b1, 1'b0, -1);
        idle(10, 1'b1);
        check("t4_valid_held", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h01);
        check("t4_overrun", ov_seen, 1);
        ready_mode = 1;
        idle(5, 1'b1);
        check("t4_count", got.size(), 1);
        check("t4_byte", got[0], 8'h01);

        // Reset during bit 4 of 0xFF, then a fresh frame.
        got.delete(); fe_seen = 0; ov_seen = 0;
        send_frame(8'hFF, 1'b1, 1'b0, 4);
        idle(10, 1'b1);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(20, 1'b1);
        check("t5_count", got.size(), 1);
        check("t5_byte", got[0], 8'h81);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inversions at each data mid-sample are outvoted.
        got.delete(); fe_seen = 0; ov_seen = 0;
        send_frame(8'hC3, 1'b1, 1'b1, -1);
        idle(20, 1'b1);
        check("t6_count", got.size(), 1);
        check("t6_byte", got[0], 8'hC3);
        check("t6_latency", rise_e - last_fe, 155);
`endif

        // Randomized traffic with a randomly stalling consumer.
        ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0)      send_glitch($urandom_range(1, H - 2));
            else if (kind == 1) send_frame(8'($urandom), 1'b0, 1'b0, -1);
            else                send_frame(8'($urandom), 1'b1, 1'b0, -1);
            idle($urandom_range(3, 12), 1'b1);
        end
        ready_mode = 1;
        idle(30, 1'b1);
        check("end_queue_empty", q.size(), 0);
        check("end_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
